fork_sched: RTL
===============

# fork_sched

Fork scheduler for the multi-core array. It collects FORK requests from running cores and grants one per cycle, round-robin. Accepted contexts are queued in a small FIFO, and each queued fork is dispatched to the lowest-index idle core. The block owns the per-core enable vector and the per-core fork context `{start, ptr, pc}` (33 bits/core) that seed each core's fetch and data-pointer state.

## Interface
Parameters:
- `NCORES`, 4, number of cores; legal range 2..16.
- `QDEPTH`, 4, pending-fork FIFO depth; power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `fork_req`  in  NCORES  core i requests a fork; held until acked.
- `fork_ptr`  in  NCORES*16  data pointer of requester i, slice `[i*16 +: 16]`.
- `fork_pc`  in  NCORES*16  target pc of requester i, `{4'b0000, imm12}`.
- `fork_ack`  out  NCORES  one-hot, combinational; request i accepted on this edge.
- `core_halt`  in  NCORES  core i finished; releases its slot.
- `core_ens`  out  NCORES  registered core enable vector.
- `fork_cxt`  out  NCORES*33  slice `[i*33 +: 33]` = `{start, ptr[15:0], pc[15:0]}`, registered.
- `q_full`  out  1  registered; count == QDEPTH.
- `q_count`  out  $clog2(QDEPTH+1)  registered FIFO occupancy.

## Operation
Reset values:
- `core_ens` = 1 (core 0 only).
- All `fork_cxt` = 0.
- FIFO empty; `q_count` = 0; `q_full` = 0.
- Round-robin pointer = 0.

Accept:
- Eligible requester: `fork_req[i] && core_ens[i]`. Requests from disabled cores are ignored and never acked.
- If `q_count < QDEPTH`, grant the first eligible i, searching from the rr pointer upward with wrap. Assert `fork_ack[i]`, push `{fork_ptr[i], fork_pc[i]}`, then set rr pointer = (i+1) mod NCORES.
- When the FIFO is full, no ack and no pointer change, even if a pop occurs on the same edge.

Dispatch:
- Idle core: `core_ens[j] == 0` at the current edge.
- If the FIFO is non-empty and an idle core exists, pop the head to the lowest-index idle j. Set `core_ens[j]` <= 1 and `fork_cxt[j]` <= `{1, ptr, pc}`.
- Only one dispatch per cycle.
- `start` is a one-cycle pulse: cleared the next edge; ptr/pc held until the next dispatch to that core.

Halt:
- `core_halt[i] && core_ens[i]`: `core_ens[i]` <= 0 at the edge.
- A core halting this cycle is not idle until the following cycle, so no same-edge redispatch.
- Halt on a disabled core is ignored.
- Fork request and halt from the same core in one cycle: the fork is still eligible, and the halt applies.
- Halting core 0 is legal. With all cores disabled and the FIFO empty, the system is idle until reset.

Counters:
- Simultaneous push and pop: count unchanged.
- FIFO pointers are log2(QDEPTH) bits and wrap naturally.
- Reset mid-operation drops all queued forks and returns every output to its reset value immediately.

## Timing
- `fork_ack` is combinational from `fork_req`, `core_ens` and `q_count` in the same cycle; the push occurs at the edge ending that cycle.
- Default latency: request acked at edge N; `core_ens`/`start` high after edge N+1, provided an idle core exists.
- `q_count` and `q_full` reflect state after each edge.
- Throughput: one accept and one dispatch per cycle.

## Configuration
Macro `FORK_SCHED_BYPASS_EN`:
- Defined: if the FIFO is empty and an idle core exists, a granted request dispatches directly at edge N with no FIFO write. `core_ens`/`start` are then high after edge N, giving 1-edge latency; `q_count` stays 0. The dispatch-per-cycle limit still holds.
- Undefined: every fork passes through the FIFO; minimum latency is 2 edges.

## Test plan
- Reset, then core 0 requests ptr=0x0010, pc=0x0123 → ack[0] in the request cycle; core 1 enabled with `fork_cxt[1]` = `{1, 0x0010, 0x0123}` for one cycle, then start=0. Edge N+1 without the macro, edge N with it.
- Cores 0..3 all enabled, all request simultaneously → acks in order 0,1,2,3 on consecutive cycles; rr pointer ends at 0.
- QDEPTH=4, all cores busy, five requests → four acks; `q_full`=1 and `q_count`=4; fifth request stalls. Halt core 2 → core 2 re-enabled from the head two edges after the halt; fifth request then acked.
- `core_halt[3]` asserted in the same cycle the FIFO is non-empty and core 3 is the only idle candidate next → no dispatch to core 3 that edge; dispatch on the following edge.
- Assert `rst` mid-operation with `q_count`=3 → all outputs return to reset values asynchronously; `core_ens`=0001 and `q_count`=0.
- Request from disabled core 2 → never acked; `q_count` unchanged.

Source files
------------

// File: rtl/fork_sched_if.sv
// Fork scheduler bus: core fork requests/acks, halts, enables and per-core contexts.
interface fork_sched_if #(
   parameter int NCORES = 4,
   parameter int QDEPTH = 4
);
   logic [NCORES-1:0]            fork_req;
   logic [NCORES*16-1:0]         fork_ptr;
   logic [NCORES*16-1:0]         fork_pc;
   logic [NCORES-1:0]            fork_ack;
   logic [NCORES-1:0]            core_halt;
   logic [NCORES-1:0]            core_ens;
   logic [NCORES*33-1:0]         fork_cxt;
   logic                         q_full;
   logic [$clog2(QDEPTH+1)-1:0]  q_count;

   modport master (
      output fork_req, fork_ptr, fork_pc, core_halt,
      input  fork_ack, core_ens, fork_cxt, q_full, q_count
   );

   modport slave (
      input  fork_req, fork_ptr, fork_pc, core_halt,
      output fork_ack, core_ens, fork_cxt, q_full, q_count
   );
endinterface

// File: rtl/fork_sched.sv
// Round-robin fork acceptor with pending-fork FIFO dispatching to the lowest idle core.
// Optional FORK_SCHED_BYPASS_EN: empty FIFO + idle core dispatches a grant directly.
module fork_sched #(
   parameter int NCORES = 4,
   parameter int QDEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   fork_sched_if.slave    bus
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH+1);
   localparam int RW = $clog2(NCORES);

   logic [NCORES-1:0] ens_q, ens_d;
   logic [NCORES-1:0] start_q;
   logic [15:0]       ptr_q [NCORES];
   logic [15:0]       pc_q  [NCORES];
   logic [31:0]       mem   [QDEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              full_q;
   logic [RW-1:0]     rr_q;

   logic [NCORES-1:0] eligible;
   logic              grant;
   logic [RW-1:0]     gnt_idx;
   logic              idle_any;
   logic [RW-1:0]     idle_idx;
   logic              q_empty, push, pop, bypass, disp;
   logic [31:0]       req_data, disp_data;
   int unsigned       idx;

   always_comb begin
      eligible = bus.fork_req & ens_q;
      grant    = 1'b0;
      gnt_idx  = '0;
      idx      = 0;
      if (cnt_q < CW'(QDEPTH)) begin
         for (int unsigned k = 0; k < NCORES; k++) begin
            idx = (32'(rr_q) + k) % NCORES;
            if (!grant && eligible[RW'(idx)]) begin
               grant   = 1'b1;
               gnt_idx = RW'(idx);
            end
         end
      end

      idle_any = 1'b0;
      idle_idx = '0;
      for (int unsigned j = 0; j < NCORES; j++) begin
         if (!idle_any && !ens_q[j]) begin
            idle_any = 1'b1;
            idle_idx = RW'(j);
         end
      end

      req_data = {bus.fork_ptr[gnt_idx*16 +: 16], bus.fork_pc[gnt_idx*16 +: 16]};
      q_empty  = (cnt_q == '0);
      pop      = !q_empty && idle_any;
`ifdef FORK_SCHED_BYPASS_EN
      bypass   = q_empty && idle_any && grant;
`else
      bypass   = 1'b0;
`endif
      push      = grant && !bypass;
      disp      = pop || bypass;
      disp_data = pop ? mem[rd_q] : req_data;

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      // Halting cores only go idle after the edge, so idle_idx never picks one this cycle.
      ens_d = ens_q & ~bus.core_halt;
      if (disp) ens_d[idle_idx] = 1'b1;

      bus.fork_ack = grant ? (NCORES'(1) << gnt_idx) : '0;
   end

   always_comb begin
      for (int unsigned i = 0; i < NCORES; i++)
         bus.fork_cxt[i*33 +: 33] = {start_q[i], ptr_q[i], pc_q[i]};
   end

   assign bus.core_ens = ens_q;
   assign bus.q_full   = full_q;
   assign bus.q_count  = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ens_q   <= NCORES'(1);
         start_q <= '0;
         for (int unsigned i = 0; i < NCORES; i++) begin
            ptr_q[i] <= '0;
            pc_q[i]  <= '0;
         end
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
         rr_q   <= '0;
      end else begin
         ens_q   <= ens_d;
         start_q <= '0;
         if (disp) begin
            start_q[idle_idx] <= 1'b1;
            ptr_q[idle_idx]   <= disp_data[31:16];
            pc_q[idle_idx]    <= disp_data[15:0];
         end
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         if (grant) rr_q <= (gnt_idx == RW'(NCORES-1)) ? '0 : gnt_idx + 1'b1;
         cnt_q  <= cnt_d;
         full_q <= (cnt_d == CW'(QDEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= req_data;
   end
endmodule
